arbiter_rr: RTL and testbench



---
 rtl/arbiter_pkg.sv | 18 +
 rtl/arbiter_rr_if.sv | 31 +++
 rtl/arbiter_pick.sv | 41 ++++
 rtl/arbiter_rr.sv | 125 ++++++++++++
 tb/tb_arbiter_rr.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the shared-memory-port arbiter and its pick logic.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Width of a client index; a single client still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbiter_rr_if.sv
// Request/grant bundle between the memory-port clients and arbiter_rr.
interface arbiter_rr_if
  import arbiter_pkg::*;
#(
  parameter int CLIENTS = 4,
  parameter int ID_W    = id_width(CLIENTS)
);

  logic [CLIENTS-1:0] request;
  logic [CLIENTS-1:0] grant;
  logic [ID_W-1:0]    owner;
  logic               busy;
  logic               timeout;

  modport master (
    output request,
    input  grant,
    input  owner,
    input  busy,
    input  timeout
  );

  modport slave (
    input  request,
    output grant,
    output owner,
    output busy,
    output timeout
  );

endinterface

// File: rtl/arbiter_pick.sv
// Combinational winner search: lowest index (mode 0) or cyclic from pointer+1 (mode 1).
module arbiter_pick
  import arbiter_pkg::*;
#(
  parameter int CLIENTS = 4,
  parameter int ID_W    = id_width(CLIENTS)
) (
  input  logic [CLIENTS-1:0] request,
  input  logic [CLIENTS-1:0] mask,
  input  logic [ID_W-1:0]    pointer,
  input  logic               mode,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  logic [CLIENTS-1:0] eligible;

  assign eligible = request & ~mask;

  always_comb begin
    int start;
    int slot;
    logic [ID_W-1:0] slot_id;
    found   = 1'b0;
    index   = '0;
    slot    = 0;
    slot_id = '0;
    // A pointer on the last client (or out of range) wraps the search to client 0.
    start = (mode && (int'(pointer) < CLIENTS - 1)) ? int'(pointer) + 1 : 0;
    for (int k = 0; k < CLIENTS; k++) begin
      slot = start + k;
      if (slot >= CLIENTS) slot = slot - CLIENTS;
      slot_id = ID_W'(slot);
      if (!found && eligible[slot_id]) begin
        found = 1'b1;
        index = slot_id;
      end
    end
  end

endmodule

// File: rtl/arbiter_rr.sv
// N-client shared memory port arbiter: fixed or round-robin policy, held grants, one-cycle gap.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles with a timeout pulse.
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int CLIENTS  = 4,
  parameter int MODE     = MODE_RR,
  parameter int MAX_HOLD = 64
) (
  input  logic        clk,
  input  logic        rst,
  arbiter_rr_if.slave bus
);

  localparam int   ID_W    = id_width(CLIENTS);
  localparam logic MODE_BIT = (MODE == MODE_RR);

  if (CLIENTS < 2 || CLIENTS > 16 || MAX_HOLD < 1 ||
      (MODE != MODE_FIXED && MODE != MODE_RR)) begin : g_bad_param
    $error("arbiter_rr: parameter out of range");
  end

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [ID_W-1:0]    owner_q;
  logic [ID_W-1:0]    pointer_q;
  logic [CLIENTS-1:0] owner_onehot;
  logic [CLIENTS-1:0] pick_mask;
  logic               owner_req;
  logic               force_release;
  logic               timeout_q;
  logic               pick_found;
  logic [ID_W-1:0]    pick_index;
  logic               win;

  assign owner_onehot = CLIENTS'(1) << owner_q;
  assign owner_req    = |(bus.request & owner_onehot);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0] hold_cnt;

  // Counter sits at zero outside GRANT, so every new grant starts counting from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state != GRANT) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign force_release = (state == GRANT) && owner_req &&
                         (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_release;
    end
  end

  // The client just timed out sits out the arbitration of this one gap.
  assign pick_mask = (state == GAP && timeout_q) ? owner_onehot : '0;
`else
  assign force_release = 1'b0;
  assign timeout_q     = 1'b0;
  assign pick_mask     = '0;
`endif

  arbiter_pick #(
    .CLIENTS (CLIENTS),
    .ID_W    (ID_W)
  ) u_pick (
    .request (bus.request),
    .mask    (pick_mask),
    .pointer (pointer_q),
    .mode    (MODE_BIT),
    .found   (pick_found),
    .index   (pick_index)
  );

  // Arbitration only counts outside GRANT; non-owners cannot pre-empt.
  assign win = (state != GRANT) && pick_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner_q   <= '0;
      pointer_q <= ID_W'(CLIENTS - 1);
    end else begin
      state <= state_nxt;
      if (win) begin
        owner_q   <= pick_index;
        pointer_q <= pick_index;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_found) state_nxt = GRANT;
      GRANT:   if (!owner_req || force_release) state_nxt = GAP;
      GAP:     state_nxt = pick_found ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.grant = '0;
    bus.busy  = 1'b0;
    if (state == GRANT) begin
      bus.grant = owner_onehot;
      bus.busy  = 1'b1;
    end
  end

  assign bus.owner   = owner_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// Self-checking bench for arbiter_rr: a 4-client round-robin and a 3-client fixed-priority instance.
module tb_arbiter_rr;
  import arbiter_pkg::*;

  localparam int NA          = 4;
  localparam int NB          = 3;
  localparam int MAX_HOLD_TB = 8;
  localparam int RAND_CYCLES = 4000;

  localparam int PH_IDLE  = 0;
  localparam int PH_OWNED = 1;
  localparam int PH_TURN  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arbiter_rr_if #(.CLIENTS(NA)) bus_a ();
  arbiter_rr_if #(.CLIENTS(NB)) bus_b ();

  arbiter_rr #(.CLIENTS(NA), .MODE(MODE_RR), .MAX_HOLD(MAX_HOLD_TB)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  arbiter_rr #(.CLIENTS(NB), .MODE(MODE_FIXED), .MAX_HOLD(MAX_HOLD_TB)) u_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  typedef struct {
    int phase;
    int own;
    int last;
    int hold;
    bit to;
  } mdl_t;

  mdl_t ma;
  mdl_t mb;
  int   errors = 0;
  int   checks = 0;
  int   held     [2][16];
  int   hold_len [2][16];

  function automatic bit bit_of(input logic [15:0] v, input int i);
    return ((v >> i) & 16'd1) != 16'd0;
  endfunction

  function automatic int pick_winner(input logic [15:0] req, input int n, input int mode,
                                     input int last, input int skip);
    int cand;
    for (int k = 0; k < n; k++) begin
      cand = (mode == MODE_RR) ? (last + 1 + k) % n : k;
      if (cand != skip && bit_of(req, cand)) return cand;
    end
    return -1;
  endfunction

  function automatic mdl_t mdl_reset(input int n);
    mdl_t r;
    r.phase = PH_IDLE;
    r.own   = 0;
    r.last  = n - 1;
    r.hold  = 0;
    r.to    = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input logic [15:0] req, input int n,
                                    input int mode);
    mdl_t r;
    int   w;
    r    = m;
    r.to = 1'b0;
    if (m.phase == PH_OWNED) begin
      if (!bit_of(req, m.own)) begin
        r.phase = PH_TURN;
      end else begin
`ifdef ARB_TIMEOUT_EN
        if (m.hold == MAX_HOLD_TB - 1) begin
          r.phase = PH_TURN;
          r.to    = 1'b1;
        end else begin
          r.hold = m.hold + 1;
        end
`endif
      end
    end else begin
      w = pick_winner(req, n, mode, m.last, (m.phase == PH_TURN && m.to) ? m.own : -1);
      if (w >= 0) begin
        r.phase = PH_OWNED;
        r.own   = w;
        r.last  = w;
        r.hold  = 0;
      end else begin
        r.phase = PH_IDLE;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mgrant(input mdl_t m);
    return (m.phase == PH_OWNED) ? (32'd1 << m.own) : 32'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= mdl_reset(NA);
      mb <= mdl_reset(NB);
    end else begin
      ma <= mdl_step(ma, 16'(bus_a.request), NA, MODE_RR);
      mb <= mdl_step(mb, 16'(bus_b.request), NB, MODE_FIXED);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("rr_grant",   32'(bus_a.grant),   mgrant(ma));
    check("rr_owner",   32'(bus_a.owner),   ma.own);
    check("rr_busy",    32'(bus_a.busy),    32'(ma.phase == PH_OWNED));
    check("rr_timeout", 32'(bus_a.timeout), 32'(ma.to));
    check("rr_onehot",  32'($onehot0(bus_a.grant)), 32'd1);
    check("fp_grant",   32'(bus_b.grant),   mgrant(mb));
    check("fp_owner",   32'(bus_b.owner),   mb.own);
    check("fp_busy",    32'(bus_b.busy),    32'(mb.phase == PH_OWNED));
    check("fp_timeout", 32'(bus_b.timeout), 32'(mb.to));
    check("fp_onehot",  32'($onehot0(bus_b.grant)), 32'd1);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic apply_reset();
    rst           = 1'b1;
    bus_a.request = '0;
    bus_b.request = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_drive(input int id, input int n, input logic [15:0] req,
                            input logic [15:0] gnt, output logic [15:0] nreq);
    nreq = req;
    for (int i = 0; i < n; i++) begin
      if (bit_of(req, i) && bit_of(gnt, i)) begin
        held[id][i]++;
        if (held[id][i] >= hold_len[id][i]) begin
          nreq        = nreq & ~(16'd1 << i);
          held[id][i] = 0;
        end
      end else if (bit_of(req, i)) begin
        if ($urandom_range(0, 39) == 0) nreq = nreq & ~(16'd1 << i);
      end else if ($urandom_range(0, 3) == 0) begin
        nreq            = nreq | (16'd1 << i);
        held[id][i]     = 0;
        hold_len[id][i] = int'($urandom_range(1, 6));
      end
    end
  endtask

  initial begin
    logic [15:0] nreq;
    int          order [5];
    order = '{0, 1, 2, 3, 0};
    bus_a.request = '0;
    bus_b.request = '0;

    // Reset state
    tick();
    check("reset_grant",   32'(bus_a.grant),   32'd0);
    check("reset_owner",   32'(bus_a.owner),   32'd0);
    check("reset_busy",    32'(bus_a.busy),    32'd0);
    check("reset_timeout", 32'(bus_a.timeout), 32'd0);

    // Two requesters from reset: client 0 first, then client 1 after a one-cycle gap
    rst           = 1'b0;
    bus_a.request = 4'b0011;
    tick();
    check("t1_first", 32'(bus_a.grant), 32'h1);
    bus_a.request = 4'b0010;
    tick();
    check("t1_gap", 32'(bus_a.grant), 32'h0);
    tick();
    check("t1_second", 32'(bus_a.grant), 32'h2);
    check("t1_owner",  32'(bus_a.owner), 32'd1);

    // All four requesting: rotation 0,1,2,3,0 with exactly one idle cycle between owners
    apply_reset();
    bus_a.request = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("t2_order", 32'(bus_a.grant), 32'd1 << order[k]);
      tick();
      tick();
      check("t2_hold", 32'(bus_a.grant), 32'd1 << order[k]);
      bus_a.request = bus_a.request & ~(4'd1 << order[k]);
      tick();
      check("t2_gap", 32'(bus_a.grant), 32'h0);
      bus_a.request = 4'b1111;
      tick();
    end

    // Fixed priority: client 1 keeps winning over 2 each time it re-requests
    apply_reset();
    bus_b.request = 3'b110;
    tick();
    check("t3_first", 32'(bus_b.grant), 32'h2);
    for (int k = 0; k < 3; k++) begin
      bus_b.request = 3'b100;
      tick();
      check("t3_gap", 32'(bus_b.grant), 32'h0);
      bus_b.request = 3'b110;
      tick();
      check("t3_regrant", 32'(bus_b.grant), 32'h2);
      check("t3_owner",   32'(bus_b.owner), 32'd1);
    end

    // Asynchronous reset in the middle of a grant
    apply_reset();
    bus_a.request = 4'b0100;
    tick();
    check("t4_granted", 32'(bus_a.grant), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("t4_async_grant", 32'(bus_a.grant), 32'h0);
    check("t4_async_busy",  32'(bus_a.busy),  32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t4_regrant", 32'(bus_a.grant), 32'h4);
    check("t4_owner",   32'(bus_a.owner), 32'd2);

`ifdef ARB_TIMEOUT_EN
    // Held request is cut off after MAX_HOLD grant cycles
    apply_reset();
    bus_a.request = 4'b0011;
    tick();
    for (int k = 0; k < MAX_HOLD_TB; k++) begin
      check("t5_hold", 32'(bus_a.grant), 32'h1);
      tick();
    end
    check("t5_gap",     32'(bus_a.grant),   32'h0);
    check("t5_timeout", 32'(bus_a.timeout), 32'd1);
    tick();
    check("t5_next", 32'(bus_a.grant), 32'h2);
`endif

    // Randomized traffic on both instances against the model
    apply_reset();
    for (int c = 0; c < RAND_CYCLES; c++) begin
      tick();
      rand_drive(0, NA, 16'(bus_a.request), 16'(bus_a.grant), nreq);
      bus_a.request = nreq[NA-1:0];
      rand_drive(1, NB, 16'(bus_b.request), 16'(bus_b.grant), nreq);
      bus_b.request = nreq[NB-1:0];
      if (c == RAND_CYCLES / 2) begin
        #2 rst = 1'b1;
        #1;
        check("rand_async_grant", 32'(bus_a.grant | 4'(bus_b.grant)), 32'h0);
        tick();
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
